weight_tile_fifo: RTL and testbench

- Parametrised, tile-granular weight FIFO that sits between the host weight stream and the MAC systolic array.
- Accepts DIM-row weight tiles over a request/sending handshake and holds up to DEPTH_TILES committed tiles.
- Streams one DIM-wide row per cycle to the array while read_en_i is high.
- Generalises the fixed 32x8-bit weight FIFO:
  - configurable array dimension, data width and tile depth;
  - explicit tile-ready and last-row flags;
  - occupancy output;
  - sticky overflow error.

---
 rtl/weight_tile_fifo_pkg.sv | 13 +
 rtl/weight_tile_fifo_tile_slot_ram.sv | 34 +++
 rtl/weight_tile_fifo.sv | 130 +++++++++++++
 tb/tb_weight_tile_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/weight_tile_fifo_pkg.sv
// Shared types for the weight tile FIFO: write FSM encoding and default row shape.
package Acc_types;
  localparam int DEFAULT_DIM    = 32;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2
  } wfifo_state_t;

  typedef logic [DEFAULT_DIM-1:0][DEFAULT_DATA_W-1:0] weight_row_t;
endpackage

// File: rtl/weight_tile_fifo_tile_slot_ram.sv
// Simple dual-port row memory: one write port, one read port with a registered output.
module tile_slot_ram
  import Acc_types::*;
#(
  parameter int ROWS = 64,
  parameter int W    = 256,
  parameter int AW   = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [ROWS];
  logic [W-1:0] rd_data_reg;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register holds its value between reads and clears on reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     rd_data_reg <= '0;
    else if (rd_en) rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/weight_tile_fifo.sv
// Tile-granular weight FIFO feeding the systolic array one row per cycle.
// Optional tile replay is enabled with the WEIGHT_FIFO_REPLAY_EN macro.
module weight_tile_fifo
  import Acc_types::*;
#(
  parameter int DIM         = 32,
  parameter int DATA_W      = 8,
  parameter int DEPTH_TILES = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                write_en_i,
  input  logic                                sending_data_i,
  input  logic [DIM*DATA_W-1:0]               data_i,
  input  logic                                read_en_i,
  input  logic                                keep_tile_i,
  output logic                                request_data_o,
  output logic                                fifo_full_o,
  output logic                                tile_rdy_o,
  output logic                                valid_o,
  output logic                                last_row_o,
  output logic [DIM*DATA_W-1:0]               data_o,
  output logic [$clog2(DEPTH_TILES+1)-1:0]    tiles_used_o,
  output logic                                overflow_err_o
);

  localparam int RW   = $clog2(DIM);
  localparam int TW   = (DEPTH_TILES > 1) ? $clog2(DEPTH_TILES) : 1;
  localparam int UW   = $clog2(DEPTH_TILES + 1);
  localparam int ROWS = DEPTH_TILES * DIM;
  localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  wfifo_state_t  state_reg, state_next;
  logic [RW-1:0] wr_row_reg, rd_row_reg;
  logic [TW-1:0] wr_tile_reg, rd_tile_reg;
  logic [UW-1:0] tiles_used_reg, tiles_used_next;
  logic          tile_rdy_reg, fifo_full_reg, valid_reg, last_row_reg, overflow_reg;

  logic row_write, last_write, pop, last_pop, free_tile, keep;
  logic [AW-1:0] wr_addr, rd_addr;

`ifdef WEIGHT_FIFO_REPLAY_EN
  assign keep = keep_tile_i;
`else
  logic unused_keep;
  assign unused_keep = keep_tile_i;
  assign keep        = 1'b0;
`endif

  assign row_write  = sending_data_i && write_en_i && ((state_reg == REQ) || (state_reg == RECV));
  assign last_write = row_write && (wr_row_reg == RW'(DIM - 1));
  assign pop        = read_en_i && tile_rdy_reg;
  assign last_pop   = pop && (rd_row_reg == RW'(DIM - 1));
  assign free_tile  = last_pop && !keep;

  // A commit and a free on the same edge cancel out.
  always_comb begin
    tiles_used_next = tiles_used_reg;
    if (last_write && !free_tile)      tiles_used_next = tiles_used_reg + UW'(1);
    else if (!last_write && free_tile) tiles_used_next = tiles_used_reg - UW'(1);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tiles_used_reg < UW'(DEPTH_TILES)) state_next = REQ;
      REQ:     if (row_write) state_next = RECV;
      RECV:    if (last_write) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= IDLE;
      wr_row_reg     <= '0;
      rd_row_reg     <= '0;
      wr_tile_reg    <= '0;
      rd_tile_reg    <= '0;
      tiles_used_reg <= '0;
      tile_rdy_reg   <= 1'b0;
      fifo_full_reg  <= 1'b0;
      valid_reg      <= 1'b0;
      last_row_reg   <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tiles_used_reg <= tiles_used_next;
      tile_rdy_reg   <= (tiles_used_next != '0);
      fifo_full_reg  <= (tiles_used_next == UW'(DEPTH_TILES));
      valid_reg      <= pop;
      last_row_reg   <= last_pop;
      if (sending_data_i && write_en_i && (state_reg == IDLE)) overflow_reg <= 1'b1;
      if (row_write) wr_row_reg <= last_write ? '0 : wr_row_reg + RW'(1);
      if (last_write)
        wr_tile_reg <= (wr_tile_reg == TW'(DEPTH_TILES - 1)) ? '0 : wr_tile_reg + TW'(1);
      // A kept tile rewinds rd_row but stays on the same slot.
      if (pop) rd_row_reg <= last_pop ? '0 : rd_row_reg + RW'(1);
      if (free_tile)
        rd_tile_reg <= (rd_tile_reg == TW'(DEPTH_TILES - 1)) ? '0 : rd_tile_reg + TW'(1);
    end
  end

  assign wr_addr = AW'(wr_tile_reg) * AW'(DIM) + AW'(wr_row_reg);
  assign rd_addr = AW'(rd_tile_reg) * AW'(DIM) + AW'(rd_row_reg);

  tile_slot_ram #(
    .ROWS (ROWS),
    .W    (DIM * DATA_W),
    .AW   (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (row_write),
    .wr_addr (wr_addr),
    .wr_data (data_i),
    .rd_en   (pop),
    .rd_addr (rd_addr),
    .rd_data (data_o)
  );

  assign request_data_o = (state_reg == REQ);
  assign fifo_full_o    = fifo_full_reg;
  assign tile_rdy_o     = tile_rdy_reg;
  assign valid_o        = valid_reg;
  assign last_row_o     = last_row_reg;
  assign tiles_used_o   = tiles_used_reg;
  assign overflow_err_o = overflow_reg;

endmodule

// File: tb/tb_weight_tile_fifo.sv
// Directed bench for weight_tile_fifo with DIM=4, DATA_W=8, DEPTH_TILES=2.
module tb_weight_tile_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        write_en = 1'b0, sending = 1'b0, read_en = 1'b0, keep_tile = 1'b0;
  logic [31:0] data_in = '0;
  logic        request_data, fifo_full, tile_rdy, valid, last_row, overflow_err;
  logic [31:0] data_out;
  logic [1:0]  tiles_used;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  weight_tile_fifo #(.DIM(4), .DATA_W(8), .DEPTH_TILES(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .write_en_i     (write_en),
    .sending_data_i (sending),
    .data_i         (data_in),
    .read_en_i      (read_en),
    .keep_tile_i    (keep_tile),
    .request_data_o (request_data),
    .fifo_full_o    (fifo_full),
    .tile_rdy_o     (tile_rdy),
    .valid_o        (valid),
    .last_row_o     (last_row),
    .data_o         (data_out),
    .tiles_used_o   (tiles_used),
    .overflow_err_o (overflow_err)
  );

  function automatic logic [31:0] mk(input logic [7:0] t, input int r);
    return {t, 8'(r), ~t, 8'h5A ^ 8'(r)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_request(input string name);
    int n = 0;
    while (request_data !== 1'b1 && n < 20) begin tick(); n++; end
    tests_run++;
    if (request_data !== 1'b1) begin fails++; $display("FAIL %s request_data_o=%b expected 1 within 20 cycles", name, request_data); end
  endtask

  task automatic send_tile(input logic [7:0] t);
    wait_request($sformatf("send_req_t%0d", t));
    for (int r = 0; r < 4; r++) begin
      sending = 1'b1; write_en = 1'b1; data_in = mk(t, r);
      tick();
    end
    sending = 1'b0;
  endtask

  task automatic read_tile(input logic [7:0] t, input logic keep_last, input logic [1:0] exp_used);
    for (int r = 0; r < 4; r++) begin
      read_en = 1'b1; keep_tile = keep_last && (r == 3);
      tick();
      tests_run++;
      if (valid !== 1'b1 || data_out !== mk(t, r) || last_row !== (r == 3)) begin
        fails++;
        $display("FAIL read_t%0d_r%0d valid=%b data=%h last=%b expected valid=1 data=%h last=%b", t, r, valid, data_out, last_row, mk(t, r), (r == 3));
      end
    end
    read_en = 1'b0; keep_tile = 1'b0;
    tests_run++;
    if (tiles_used !== exp_used) begin fails++; $display("FAIL read_t%0d_used tiles_used=%0d expected %0d", t, tiles_used, exp_used); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({request_data, fifo_full, tile_rdy, valid, last_row, overflow_err, tiles_used, data_out} !== '0) begin
      fails++; $display("FAIL reset_outputs req=%b full=%b rdy=%b valid=%b last=%b ovf=%b used=%0d data=%h expected all 0",
                        request_data, fifo_full, tile_rdy, valid, last_row, overflow_err, tiles_used, data_out);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (request_data !== 1'b1 || tiles_used !== 2'd0 || tile_rdy !== 1'b0) begin
      fails++; $display("FAIL reset_cycle1 req=%b used=%0d rdy=%b expected 1 0 0", request_data, tiles_used, tile_rdy);
    end
    for (int r = 0; r < 4; r++) begin
      sending = 1'b1; write_en = 1'b1; data_in = mk(0, r);
      tick();
      if (r == 0) begin
        tests_run++;
        if (request_data !== 1'b0) begin fails++; $display("FAIL req_drop request_data_o=%b expected 0", request_data); end
      end
      if (r == 2) begin
        tests_run++;
        if (tile_rdy !== 1'b0) begin fails++; $display("FAIL partial_not_rdy tile_rdy_o=%b expected 0", tile_rdy); end
      end
    end
    sending = 1'b0;
    tests_run++;
    if (tile_rdy !== 1'b1 || tiles_used !== 2'd1) begin
      fails++; $display("FAIL first_commit rdy=%b used=%0d expected 1 1", tile_rdy, tiles_used);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_fill();
    send_tile(1);
    tests_run++;
    if (fifo_full !== 1'b1 || tiles_used !== 2'd2) begin
      fails++; $display("FAIL fill_full full=%b used=%0d expected 1 2", fifo_full, tiles_used);
    end
    tick();
    tests_run++;
    if (request_data !== 1'b0 || overflow_err !== 1'b0) begin
      fails++; $display("FAIL full_no_req req=%b ovf=%b expected 0 0", request_data, overflow_err);
    end
    sending = 1'b1; write_en = 1'b1; data_in = mk(8'h99, 0);
    tick();
    sending = 1'b0;
    tests_run++;
    if (overflow_err !== 1'b1 || tiles_used !== 2'd2) begin
      fails++; $display("FAIL overflow_set ovf=%b used=%0d expected 1 2", overflow_err, tiles_used);
    end
    repeat (3) tick();
    tests_run++;
    if (overflow_err !== 1'b1) begin fails++; $display("FAIL overflow_sticky ovf=%b expected 1", overflow_err); end
    $display("[TB] test_fill done");
  endtask

  task automatic test_read();
    int n = 0;
    read_tile(0, 1'b0, 2'd1);
    while (request_data !== 1'b1 && n < 2) begin tick(); n++; end
    tests_run++;
    if (request_data !== 1'b1 || valid !== 1'b0) begin
      fails++; $display("FAIL read_rerequest req=%b valid=%b after %0d cycles expected req=1 valid=0 within 2", request_data, valid, n);
    end
    $display("[TB] test_read done");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      sending = 1'b1; write_en = 1'b1; data_in = mk(2, r); read_en = 1'b1;
      tick();
      tests_run++;
      if (valid !== 1'b1 || data_out !== mk(1, r) || last_row !== (r == 3)) begin
        fails++; $display("FAIL simul_r%0d valid=%b data=%h last=%b expected 1 %h %b", r, valid, data_out, last_row, mk(1, r), (r == 3));
      end
    end
    sending = 1'b0; read_en = 1'b0;
    tests_run++;
    if (tiles_used !== 2'd1 || tile_rdy !== 1'b1) begin
      fails++; $display("FAIL simul_used used=%0d rdy=%b expected 1 1", tiles_used, tile_rdy);
    end
    read_tile(2, 1'b0, 2'd0);
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_gapped();
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || data_out !== mk(2, 3)) begin
      fails++; $display("FAIL empty_read valid=%b data=%h expected 0 %h", valid, data_out, mk(2, 3));
    end
    wait_request("gap_req");
    for (int r = 0; r < 4; r++) begin
      if (r == 2) begin
        sending = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (tile_rdy !== 1'b0 || request_data !== 1'b0) begin
          fails++; $display("FAIL gap_hold rdy=%b req=%b expected 0 0", tile_rdy, request_data);
        end
      end
      sending = 1'b1; write_en = 1'b1; data_in = mk(3, r);
      tick();
    end
    sending = 1'b0;
    tests_run++;
    if (tiles_used !== 2'd1 || tile_rdy !== 1'b1) begin
      fails++; $display("FAIL gap_commit used=%0d rdy=%b expected 1 1", tiles_used, tile_rdy);
    end
    read_tile(3, 1'b0, 2'd0);
    $display("[TB] test_gapped done");
  endtask

  task automatic test_replay();
    send_tile(4);
`ifdef WEIGHT_FIFO_REPLAY_EN
    read_tile(4, 1'b1, 2'd1);
    tests_run++;
    if (tile_rdy !== 1'b1) begin fails++; $display("FAIL replay_kept tile_rdy_o=%b expected 1", tile_rdy); end
    read_tile(4, 1'b0, 2'd0);
`else
    read_tile(4, 1'b1, 2'd0);
    tests_run++;
    if (tile_rdy !== 1'b0) begin fails++; $display("FAIL noreplay_freed tile_rdy_o=%b expected 0", tile_rdy); end
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    tests_run++;
    if (valid !== 1'b0) begin fails++; $display("FAIL noreplay_empty valid=%b expected 0", valid); end
`endif
    $display("[TB] test_replay done");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read();
    test_back_to_back();
    test_gapped();
    test_replay();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
